usd_init_seq: RTL

Card-initialisation sequencer for the microSD command-line controller. After `start` it drives the command engine's `cmdReg`/`argumentReg`/`newCmd` inputs through the SD power-up sequence: CMD0, CMD8, the CMD55/ACMD41 poll loop, CMD2, CMD3 and CMD7. It checks every response, retries failed commands and reports the card's RCA and capacity class to sdEngine. It also owns the engine's `commandTimeOut` input.

---
 rtl/usd_init_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/usd_init_seq.sv
// usd_init_seq: SD card power-up sequencer. Walks CMD0, CMD8, the
// CMD55/ACMD41 poll loop, CMD2, CMD3 and CMD7 through the command engine,
// checks each response, retries failures and reports RCA and capacity class.
module usd_init_seq #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int NORESP_WAIT    = 64,
  parameter int CMD_RETRY      = 3,
  parameter int POLL_MAX       = 1000,
  parameter int POLL_GAP       = 256
) (
  input  logic         sdClk,
  input  logic         sysRstN,
  input  logic         start,
  input  logic         cmdInitDone,
  input  logic         cmdDataReady,
  input  logic         cmdStatus,
  input  logic [135:0] cmdResponse,
  output logic [15:0]  cmdReg,
  output logic [31:0]  argumentReg,
  output logic         newCmd,
  output logic         commandTimeOut,
  output logic         busy,
  output logic         cardReady,
  output logic         initError,
  output logic [3:0]   errCode,
  output logic [15:0]  rca,
  output logic         ccs
);

  typedef enum logic [3:0] {
    IDLE, WAIT_ENG, ISSUE, WAIT_RSP, SETTLE, EVAL, POLL_DLY, DONE, ERROR
  } state_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_136  = 2'b01;
  localparam logic [1:0] RSP_48   = 2'b10;

  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] NR_LAST   = 10'(NORESP_WAIT - 1);
  localparam logic [9:0] GAP_LAST  = 10'(POLL_GAP - 1);
  localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);

  state_t      state;
  logic [2:0]  step;
  logic [1:0]  retry;
  logic [9:0]  poll;
  logic [9:0]  timer;
  logic        tmo;

  logic [5:0]  st_idx;
  logic [31:0] st_arg;
  logic [1:0]  st_type;
  logic        st_crc;
  logic [15:0] st_reg;
  logic        fail;
  logic        unused_rsp;

  // Step table: command index, argument, response type and CRC enable
  always_comb begin
    st_idx  = 6'd0;
    st_arg  = 32'h0;
    st_type = RSP_NONE;
    st_crc  = 1'b0;
    case (step)
      3'd1: begin st_idx = 6'd8;  st_arg = 32'h0000_01AA; st_type = RSP_48;  st_crc = 1'b1; end
      3'd2: begin st_idx = 6'd55; st_type = RSP_48;  st_crc = 1'b1; end
      3'd3: begin st_idx = 6'd41; st_arg = 32'h40FF_8000; st_type = RSP_48; end
      3'd4: begin st_idx = 6'd2;  st_type = RSP_136; end
      3'd5: begin st_idx = 6'd3;  st_type = RSP_48;  st_crc = 1'b1; end
      3'd6: begin st_idx = 6'd7;  st_arg = {rca, 16'h0}; st_type = RSP_48; st_crc = 1'b1; end
      default: ;
    endcase
  end

  assign st_reg = {2'b00, st_idx, 4'b0000, st_crc, 1'b0, st_type};

  // A timeout, a CRC error on a checked command or a bad CMD8 echo all fail
  assign fail = tmo | (cmdStatus & cmdReg[3]) |
                ((step == 3'd1) && (cmdResponse[19:8] != 12'h1AA));

  // Only the status fields of the response are ever inspected
  assign unused_rsp = ^{cmdResponse[135:40], cmdResponse[23:20], cmdResponse[7:0]};

  // Sequencer FSM with registered outputs
  always_ff @(posedge sdClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state          <= IDLE;
      step           <= 3'd0;
      retry          <= 2'd0;
      poll           <= 10'd0;
      timer          <= 10'd0;
      tmo            <= 1'b0;
      cmdReg         <= 16'h0;
      argumentReg    <= 32'h0;
      newCmd         <= 1'b0;
      commandTimeOut <= 1'b0;
      busy           <= 1'b0;
      cardReady      <= 1'b0;
      initError      <= 1'b0;
      errCode        <= 4'd0;
      rca            <= 16'h0;
      ccs            <= 1'b0;
    end else begin
      newCmd         <= 1'b0;
      commandTimeOut <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= WAIT_ENG;
            step      <= 3'd0;
            retry     <= 2'd0;
            poll      <= 10'd0;
            busy      <= 1'b1;
            cardReady <= 1'b0;
            initError <= 1'b0;
          end
        end
        WAIT_ENG: begin
          if (cmdInitDone) begin
            state       <= ISSUE;
            cmdReg      <= st_reg;
            argumentReg <= st_arg;
          end
        end
        ISSUE: begin
          newCmd <= 1'b1;
          timer  <= 10'd0;
          tmo    <= 1'b0;
          state  <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (cmdReg[1:0] == RSP_NONE) begin
            if (timer == NR_LAST) state <= EVAL;
            else if (timer != 10'h3FF) timer <= timer + 10'd1;
          end else if (cmdDataReady) begin
            // a response arriving on the terminal count beats the timeout
            state <= SETTLE;
            timer <= 10'd0;
          end else if (timer == TMO_LAST) begin
            commandTimeOut <= 1'b1;
            tmo            <= 1'b1;
            state          <= EVAL;
          end else if (timer != 10'h3FF) begin
            timer <= timer + 10'd1;
          end
        end
        SETTLE: begin
          // two cycles for the engine's CRC status to become valid
          if (timer == 10'd1) state <= EVAL;
          else timer <= timer + 10'd1;
        end
        EVAL: begin
          if (fail) begin
            if (int'(retry) < CMD_RETRY) begin
              retry <= retry + 2'd1;
              state <= WAIT_ENG;
            end else begin
              state     <= ERROR;
              errCode   <= {1'b0, step};
              initError <= 1'b1;
              busy      <= 1'b0;
            end
          end else if ((step == 3'd3) && !cmdResponse[39]) begin
            retry <= 2'd0;
            poll  <= poll + 10'd1;
            if (poll == POLL_LAST) begin
              state     <= ERROR;
              errCode   <= 4'd3;
              initError <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= POLL_DLY;
              timer <= 10'd0;
            end
          end else begin
            retry <= 2'd0;
            if (step == 3'd3) ccs <= cmdResponse[38];
            if (step == 3'd5) rca <= cmdResponse[39:24];
            if (step == 3'd6) begin
              state     <= DONE;
              cardReady <= 1'b1;
              busy      <= 1'b0;
            end else begin
              step  <= step + 3'd1;
              state <= WAIT_ENG;
            end
          end
        end
        POLL_DLY: begin
          if (timer == GAP_LAST) begin
            step  <= 3'd2;
            state <= WAIT_ENG;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
